// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one encoded op at a time to a one-hot-select ALU and returns its 64-bit result.
// Build option ALU_SEQ_DIVZERO_EN: reject DIV with b_in == 0 (err=1, Z cleared) instead of issuing it.
module alu_op_sequencer #(
    parameter int unsigned MUL_WAIT = 1,
    parameter int unsigned DIV_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_code,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [12:0] alu_sel,
    input  logic [63:0] alu_c,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
    localparam logic [3:0] OP_MAX = 4'd12;
    localparam logic [3:0] MUL_W  = 4'(MUL_WAIT);
    localparam logic [3:0] DIV_W  = 4'(DIV_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] z_hi_q, z_hi_d;
    logic [31:0] z_lo_q, z_lo_d;
    logic        err_q, err_d;
    logic        reject_q, reject_d;
    logic        zero_z_q, zero_z_d;
    logic        rdy_q;

    logic        accept;
    logic        illegal;
    logic        div_zero;
    logic [3:0]  wait_cnt;

    always_comb begin
`ifdef ALU_SEQ_DIVZERO_EN
        div_zero = (op_code == OP_DIV) && (b_in == 32'd0);
`else
        div_zero = 1'b0;
`endif
        illegal  = (op_code > OP_MAX);
        if (op_code == OP_MUL)      wait_cnt = MUL_W;
        else if (op_code == OP_DIV) wait_cnt = DIV_W;
        else                        wait_cnt = 4'd0;
    end

    assign accept = op_valid && op_ready;

    always_comb begin
        // NOTE: every next-state signal defaults to its register first, so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        z_hi_d   = z_hi_q;
        z_lo_d   = z_lo_q;
        err_d    = err_q;
        reject_d = reject_q;
        zero_z_d = zero_z_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d     = op_code;
                    a_d      = a_in;
                    b_d      = b_in;
                    cnt_d    = wait_cnt;
                    reject_d = illegal || div_zero;
                    zero_z_d = div_zero && !illegal;
                    // Rejected requests pass through CAPTURE so res_valid lands one edge after acceptance.
                    if (illegal || div_zero)  state_d = S_CAPTURE;
                    else if (wait_cnt != 4'd0) state_d = S_SETTLE;
                    else                       state_d = S_ISSUE;
                end
            end
            S_SETTLE: begin
                if (cnt_q <= 4'd1) state_d = S_ISSUE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (reject_q) begin
                    err_d = 1'b1;
                    if (zero_z_q) begin
                        z_hi_d = 32'd0;
                        z_lo_d = 32'd0;
                    end
                end else begin
                    err_d  = 1'b0;
                    z_hi_d = alu_c[63:32];
                    z_lo_d = alu_c[31:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            cnt_q    <= 4'd0;
            z_hi_q   <= 32'd0;
            z_lo_q   <= 32'd0;
            err_q    <= 1'b0;
            reject_q <= 1'b0;
            zero_z_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            z_hi_q   <= z_hi_d;
            z_lo_q   <= z_lo_d;
            err_q    <= err_d;
            reject_q <= reject_d;
            zero_z_q <= zero_z_d;
            rdy_q    <= 1'b1;
        end
    end

    // rdy_q keeps op_ready low while reset is held even though the state already reads IDLE.
    assign op_ready  = rdy_q && (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign alu_sel   = (state_q == S_ISSUE) ? (13'd1 << op_q) : 13'd0;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign z_hi      = z_hi_q;
    assign z_lo      = z_lo_q;
    assign err       = err_q;

endmodule
